// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: fetch PC, one outstanding 8-byte-aligned memory read,
// 32-bit word select, and a small instruction FIFO toward decode.
module ysyx_22040127_ifu #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e             state_q;
  logic [63:0]        fetch_pc_q;
  logic [63:0]        req_pc_q;
  logic               drop_q;
  logic               req_valid_q;
  logic [63:0]        req_addr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [31:0]        buf_inst_q [BUF_DEPTH];
  logic [63:0]        buf_pc_q   [BUF_DEPTH];

  logic               handshake;
  logic               push_en;
  logic               pop_en;
  logic [31:0]        word;
  logic [63:0]        redir_pc_w;
  logic               unused_redir_bits;

  function automatic logic [63:0] line_addr(input logic [63:0] pc);
    return {pc[63:3], 3'b000};
  endfunction

  assign handshake  = (state_q == S_REQ) && imem_req_ready;
  assign word       = req_pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
  assign redir_pc_w = {redirect_pc[63:2], 2'b00};
  assign unused_redir_bits = ^redirect_pc[1:0];

  // A response is pushed only if it is neither stale nor overtaken by a redirect
  assign push_en = (state_q == S_WAIT) && imem_resp_valid && !drop_q && !redirect_valid;
  assign pop_en  = inst_valid && inst_ready;
  assign cnt_d   = redirect_valid ? '0 : cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (cnt_q != '0);
  assign inst           = inst_valid ? buf_inst_q[rptr_q] : '0;
  assign inst_pc        = inst_valid ? buf_pc_q[rptr_q]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (redirect_valid) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_en) wptr_q <= wptr_q + PTR_W'(1);
        if (pop_en)  rptr_q <= rptr_q + PTR_W'(1);
      end

      if (redirect_valid) begin
        fetch_pc_q <= redir_pc_w;
        unique case (state_q)
          S_REQ: begin
            if (handshake) begin
              drop_q      <= 1'b1;
              state_q     <= S_WAIT;
              req_valid_q <= 1'b0;
            end else begin
              req_addr_q  <= line_addr(redir_pc_w);
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              drop_q      <= 1'b0;
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= line_addr(redir_pc_w);
            end else begin
              drop_q      <= 1'b1;
            end
          end
          default: begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= line_addr(redir_pc_w);
          end
        endcase
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cnt_q < DEPTH_C) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= line_addr(fetch_pc_q);
            end
          end
          S_REQ: begin
            if (handshake) begin
              fetch_pc_q  <= fetch_pc_q + 64'd4;
              state_q     <= S_WAIT;
              req_valid_q <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              drop_q <= 1'b0;
              // Issue the next request only when its response is sure of a slot
              if (cnt_d < DEPTH_C) begin
                state_q     <= S_REQ;
                req_valid_q <= 1'b1;
                req_addr_q  <= line_addr(fetch_pc_q);
              end else begin
                state_q     <= S_IDLE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) req_pc_q <= fetch_pc_q;
    if (push_en) begin
      buf_inst_q[wptr_q] <= word;
      buf_pc_q[wptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: doc/ysyx_22040127_ifu.md
Name: ysyx_22040127_ifu

Overview:
Instruction fetch unit. It produces the 32-bit instruction stream that the decode stage consumes. It keeps the fetch PC, issues 8-byte-aligned reads to instruction memory with at most one read outstanding, and selects the 32-bit word from each response. Instructions and their PCs go into a small FIFO, which is presented to decode through a valid/ready handshake. A redirect from execute (branch, jump or jalr target) flushes in-flight and buffered instructions.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, first PC fetched after reset
BUF_DEPTH, 2, instruction FIFO entries (power of two, minimum 2)

Ports:
clk  input  1  clock
rst  input  1  reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  64  read address, bits[2:0] always 0
imem_resp_valid  input  1  read data valid (single cycle, in request order)
imem_resp_data  input  64  read data
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  64  new fetch PC
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode accepts head
inst  output  32  head instruction
inst_pc  output  64  head PC

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. Instruction memory shares rst, so no response arrives from before reset.
- Reset values:
  - fetch_pc = RESET_PC; state = IDLE.
  - FIFO count = 0, drop flag = 0.
  - imem_req_valid = 0, imem_req_addr = 0.
  - inst_valid = 0, inst = 0, inst_pc = 0.
- State IDLE:
  - imem_req_valid = 0.
  - Go to REQ when count + inflight < BUF_DEPTH.
- State REQ:
  - imem_req_valid = 1; imem_req_addr = {fetch_pc[63:3], 3'b000}.
  - Without a redirect, address and valid stay stable until imem_req_ready.
  - On the handshake: latch req_pc = fetch_pc; fetch_pc <= fetch_pc + 4 (wraps modulo 2^64); go to WAIT.
- State WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid, push {word, req_pc}, where word = req_pc[2] ? data[63:32] : data[31:0].
  - Then go to REQ if space remains after the push, otherwise IDLE.
- Space accounting:
  - inflight = 1 in WAIT, or in the REQ handshake cycle.
  - No request is issued unless its response is guaranteed a FIFO slot, so the FIFO never overflows.
- FIFO and decode handshake:
  - inst_valid = (count != 0); inst and inst_pc show the head entry.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Head fields are held stable while inst_valid && !inst_ready.
- Latency:
  - Request handshake at cycle t, response at cycle t+k → inst_valid = 1 at cycle t+k+1.
  - Back-to-back: the next request can be issued in the cycle after the response.
- Redirect (highest priority, takes effect at the next clock edge):
  - FIFO is flushed (count = 0); inst_valid = 0 next cycle.
  - fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - In REQ without a handshake, the pending request is withdrawn and REQ re-enters with the new address. Memory samples the address only on a handshake.
  - In REQ with a handshake in the same cycle, the request counts as issued: drop = 1, go to WAIT.
  - In WAIT with no response this cycle: drop = 1, stay in WAIT.
  - A response arriving in the same cycle as the redirect is discarded; go to REQ with the new PC.
  - In IDLE: go to REQ.
  - A pop in the redirect cycle still counts as a valid transfer to decode.
- Drop flag:
  - The next imem_resp_valid while drop = 1 is discarded (no push) and clears drop.
  - The FSM then goes to REQ with the redirected fetch_pc.
  - A second redirect while drop = 1 only updates fetch_pc; exactly one response is still discarded.
- Reset mid-operation: all state returns to reset values at the next edge. Any partial request is abandoned.

Test Plan:
1. Reset release, memory that is always ready with 1-cycle response and words 0x00000013/0x00100093 at 0x80000000 → inst_pc 0x80000000 then 0x80000004, inst 0x00000013 then 0x00100093, both words taken from one 64-bit line.
2. inst_ready held 0 → after 2 instructions imem_req_valid stays 0 and the head stays stable. Release inst_ready → fetch resumes at 0x80000008 with no lost or duplicated PCs.
3. Redirect to 0x80001006 in the same cycle as a response at PC 0x80000010 → that response is dropped, FIFO is emptied, and the next request address is 0x80001000 with inst_pc 0x80001004.
4. Redirect while in WAIT with a 5-cycle memory → one stale response is discarded, then the first fetched inst_pc equals the redirect target. Test two redirects during the same WAIT → only the last target is fetched.
5. imem_req_ready held low for 4 cycles → imem_req_addr stays stable. Apply a redirect during the stall → the address changes to the new target without a handshake being counted.
6. redirect_pc = 0xFFFFFFFFFFFFFFFC → fetches at ...FFFC then 0x0000000000000000 (PC wrap-around). Assert rst mid-WAIT → the first request after reset is to RESET_PC.
